// File: rtl/hs_npu_mem_responder.sv
// NPU memory responder: turns single-beat read/write requests from an
// initiator into BURST_SIZE consecutive SRAM word accesses.
//
// state | meaning
// IDLE  | ready for a beat; captures address (and write data)
// READ  | issues one SRAM read per cycle, registers returned words
// RESP  | presents the read beat for one cycle
// WRITE | issues one SRAM write per cycle from captured data
module hs_npu_mem_responder #(
  parameter int BURST_SIZE = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_ready_i,
  input  logic                  mem_write_valid_i,
  input  logic                  mem_invalidate_i,
  input  logic [31:0]           request_address_i,
  input  logic [31:0]           memory_data_i [BURST_SIZE],
  output logic                  mem_valid_o,
  output logic                  mem_ready_o,
  output logic [31:0]           memory_data_o [BURST_SIZE],
  output logic                  addr_error_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  localparam int CW = $clog2(BURST_SIZE + 1);

  typedef enum logic [1:0] {IDLE, READ, RESP, WRITE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  bad_q;
  logic                  err_q;
  logic [31:0]           wbuf [BURST_SIZE];
  logic [31:0]           rbuf [BURST_SIZE];
  logic [31:0]           hold [BURST_SIZE];
  logic                  addr_bad;
  logic                  issue;
  logic                  strobe;
  logic [31:0]           wsel;

  // Misaligned byte address, or any bit beyond the SRAM word range set.
  assign addr_bad = (request_address_i[1:0] != 2'b00) ||
                    ((request_address_i >> (ADDR_WIDTH + 2)) != 32'd0);

  // Next-state selection; write wins over read in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_write_valid_i) state_nxt = WRITE;
        else if (mem_read_ready_i && !mem_invalidate_i) state_nxt = READ;
      end
      READ: begin
        if (mem_invalidate_i) state_nxt = IDLE;
        else if (cnt == CW'(BURST_SIZE)) state_nxt = RESP;
      end
      RESP:  state_nxt = IDLE;
      WRITE: if (cnt == CW'(BURST_SIZE - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; reset gates strobes in the reset cycle itself
  // so an aborted write never lands another word.
  always_comb begin
    mem_ready_o  = (state == IDLE);
    mem_valid_o  = (state == RESP) && !rst;
    addr_error_o = err_q && !rst;
    // READ keeps one extra cycle (cnt == BURST_SIZE) only to capture the last word.
    issue        = ((state == READ) && (cnt < CW'(BURST_SIZE))) || (state == WRITE);
    strobe       = issue && !bad_q && !rst;
    sram_req_o   = strobe;
    sram_we_o    = strobe && (state == WRITE);
    sram_addr_o  = strobe ? base + ADDR_WIDTH'(cnt) : '0;
    wsel         = 32'd0;
    for (int i = 0; i < BURST_SIZE; i++) begin
      if (cnt == CW'(i)) wsel = wbuf[i];
    end
    sram_wdata_o = sram_we_o ? wsel : 32'd0;
    for (int i = 0; i < BURST_SIZE; i++) begin
      if (rst) memory_data_o[i] = 32'd0;
      else if (state == RESP) memory_data_o[i] = rbuf[i];
      else memory_data_o[i] = hold[i];
    end
  end

  // State, beat counter, capture registers and read buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < BURST_SIZE; i++) begin
        wbuf[i] <= 32'd0;
        rbuf[i] <= 32'd0;
        hold[i] <= 32'd0;
      end
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (state_nxt != IDLE) begin
            base  <= request_address_i[ADDR_WIDTH+1:2];
            bad_q <= addr_bad;
            err_q <= addr_bad;
            for (int i = 0; i < BURST_SIZE; i++) begin
              if (mem_write_valid_i) wbuf[i] <= memory_data_i[i];
              // A bad read answers with zeros, so start every read from a clean buffer.
              else rbuf[i] <= 32'd0;
            end
          end
        end
        READ: begin
          cnt <= cnt + CW'(1);
          if (!bad_q) begin
            for (int i = 0; i < BURST_SIZE; i++) begin
              if (cnt == CW'(i + 1)) rbuf[i] <= sram_rdata_i;
            end
          end
        end
        RESP: begin
          for (int i = 0; i < BURST_SIZE; i++) hold[i] <= rbuf[i];
        end
        WRITE: cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_npu_mem_responder.sv
// Bench for hs_npu_mem_responder: directed scenarios then random traffic,
// responses checked by a queue-based scoreboard against a memory model.
module tb_hs_npu_mem_responder;

  localparam int B  = 2;
  localparam int AW = 16;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [32*B-1:0] d;
    int              cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic rd_ready, wr_valid, inval;
  logic [31:0] req_addr;
  logic [31:0] wdata_in [B];
  logic mem_valid, mem_ready, addr_error, sram_req, sram_we;
  logic [31:0] rdata_out [B];
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic [31:0] sram_m [DEPTH];
  logic [31:0] ref_m  [DEPTH];

  resp_t resp_q [$];
  int    err_q  [$];
  logic [32*B-1:0] last_d;

  int tests = 0, fails = 0, cyc = 0, req_cnt = 0;
  bit started = 1'b0;

  hs_npu_mem_responder #(.BURST_SIZE(B), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_read_ready_i(rd_ready), .mem_write_valid_i(wr_valid),
    .mem_invalidate_i(inval), .request_address_i(req_addr),
    .memory_data_i(wdata_in), .mem_valid_o(mem_valid), .mem_ready_o(mem_ready),
    .memory_data_o(rdata_out), .addr_error_o(addr_error),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: read data valid the cycle after a read strobe, junk otherwise.
  always @(posedge clk) begin
    if (sram_req && sram_we) sram_m[sram_addr] <= sram_wdata;
    if (sram_req && !sram_we) sram_rdata <= sram_m[sram_addr];
    else sram_rdata <= $urandom;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  function automatic logic [32*B-1:0] model_read(input logic [31:0] a);
    logic [32*B-1:0] r = '0;
    int w = int'(a[AW+1:2]);
    if (!is_bad(a))
      for (int k = 0; k < B; k++) r[32*k +: 32] = ref_m[(w + k) % DEPTH];
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a beat or an error.
  always @(negedge clk) begin
    logic [32*B-1:0] got;
    resp_t e;
    if (rst) begin
      last_d = '0;
    end else if (started) begin
      for (int k = 0; k < B; k++) got[32*k +: 32] = rdata_out[k];
      if (sram_req) req_cnt++;
      if (sram_we) check("we_without_req", sram_req, 1);
      if (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        check("mem_valid_missing_at", 0, resp_q[0].cyc);
        void'(resp_q.pop_front());
      end
      if (mem_valid) begin
        if (resp_q.size() == 0) check("mem_valid_unexpected", 1, 0);
        else begin
          e = resp_q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_data", got, e.d);
          last_d = e.d;
        end
      end else begin
        check("data_hold", got, last_d);
      end
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        check("addr_error_missing_at", 0, err_q[0]);
        void'(err_q.pop_front());
      end
      if (addr_error) begin
        if (err_q.size() > 0 && err_q[0] == cyc) begin
          tests++;
          void'(err_q.pop_front());
        end else check("addr_error_unexpected", 1, 0);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge where DUT is IDLE.
  task automatic wait_idle();
    int n = 0;
    while (!mem_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!mem_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int inv_j);
    int s0, exp_s;
    resp_t e;
    wait_idle();
    s0 = req_cnt;
    req_addr = a;
    rd_ready = 1'b1;
    if (is_bad(a)) err_q.push_back(cyc + 1);
    if (inv_j < 0) begin
      e.d = model_read(a);
      e.cyc = cyc + B + 2;
      resp_q.push_back(e);
    end
    @(posedge clk); #1;
    rd_ready = 1'b0;
    if (inv_j >= 0) begin
      repeat (inv_j) begin @(posedge clk); #1; end
      inval = 1'b1;
      @(posedge clk); #1;
      inval = 1'b0;
    end
    wait_idle();
    if (is_bad(a)) exp_s = 0;
    else if (inv_j < 0) exp_s = B;
    else exp_s = (inv_j + 1 < B) ? inv_j + 1 : B;
    check("read_strobes", req_cnt - s0, exp_s);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [32*B-1:0] wd, input bit both);
    int s0, w;
    resp_t e;
    wait_idle();
    s0 = req_cnt;
    w = int'(a[AW+1:2]);
    wr_valid = 1'b1;
    rd_ready = both;
    req_addr = a;
    for (int k = 0; k < B; k++) wdata_in[k] = wd[32*k +: 32];
    if (is_bad(a)) err_q.push_back(cyc + 1);
    else for (int k = 0; k < B; k++) ref_m[(w + k) % DEPTH] = wd[32*k +: 32];
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (both) begin
      wait_idle();
      if (is_bad(a)) err_q.push_back(cyc + 1);
      e.d = model_read(a);
      e.cyc = cyc + B + 2;
      resp_q.push_back(e);
      @(posedge clk); #1;
      rd_ready = 1'b0;
      wait_idle();
    end
    check("write_strobes", req_cnt - s0, is_bad(a) ? 0 : (both ? 2 * B : B));
  endtask

  task automatic do_reset_mid_write(input logic [31:0] a, input logic [32*B-1:0] wd);
    int s0, w;
    wait_idle();
    s0 = req_cnt;
    w = int'(a[AW+1:2]);
    wr_valid = 1'b1;
    req_addr = a;
    for (int k = 0; k < B; k++) wdata_in[k] = wd[32*k +: 32];
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ref_m[w] = wd[31:0];
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_after_reset", mem_ready, 1);
    check("reset_write_strobes", req_cnt - s0, 1);
    check("partial_word0", sram_m[w], ref_m[w]);
    check("partial_word1", sram_m[(w + 1) % DEPTH], ref_m[(w + 1) % DEPTH]);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [31:0] w = (sel < 6) ? 32'h100 + $urandom_range(0, 15)
                               : 32'hFFFE + $urandom_range(0, 1);
    logic [31:0] a = (w & 32'hFFFF) << 2;
    if (sel == 8) a = a | $urandom_range(1, 3);
    if (sel == 9) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  initial begin
    logic [32*B-1:0] wd;
    int mism;
    rst = 1'b1;
    rd_ready = 1'b0; wr_valid = 1'b0; inval = 1'b0; req_addr = 32'd0;
    for (int k = 0; k < B; k++) wdata_in[k] = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_m[i] = $urandom;
      sram_m[i] <= ref_m[i];
    end
    ref_m[32'h100] = 32'hAABBCCDD;
    ref_m[32'h101] = 32'h11223344;
    sram_m[32'h100] <= 32'hAABBCCDD;
    sram_m[32'h101] <= 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_sram_req", sram_req, 0);
    check("rst_addr_error", addr_error, 0);
    check("rst_data_out", {rdata_out[1], rdata_out[0]}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", mem_ready, 1);
    started = 1'b1;

    do_read(32'h400, -1);
    do_write(32'h20, {32'd2, 32'd1}, 1'b1);
    check("write_word8", ref_m[8], 1);
    do_read(32'h402, -1);
    do_read(32'h404, 1);
    do_read(32'h404, -1);
    do_read(32'h3FFFC, -1);
    do_reset_mid_write(32'h440, {32'hBEEF0001, 32'hBEEF0000});
    do_read(32'h440, -1);

    for (int n = 0; n < 200; n++) begin
      int op = $urandom_range(0, 9);
      for (int k = 0; k < B; k++) wd[32*k +: 32] = $urandom;
      if (op < 4) do_read(rand_addr(), -1);
      else if (op < 6) do_read(rand_addr(), $urandom_range(0, B));
      else if (op < 9) do_write(rand_addr(), wd, 1'b0);
      else do_write(rand_addr(), wd, 1'b1);
    end

    repeat (B + 5) @(posedge clk);
    #1;
    check("resp_queue_drained", resp_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    check("sram_word8", sram_m[8], 1);
    check("sram_word9", sram_m[9], 2);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (sram_m[i] !== ref_m[i]) mism++;
    check("sram_contents_mismatches", mism, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
